tlc_seg_scan: RTL

Multiplexed 8-digit seven-segment scanner for the traffic-light controller. It sits directly downstream of the phase timer, which supplies the per-direction remaining-time digits. The block snapshots eight BCD digits once per frame, decodes them, and drives the shared active-low segment bus and anodes one digit at a time, with a blanking dead-time between digits.

---
 rtl/tlc_pkg.sv | 33 +++
 rtl/seg7_decode.sv | 27 ++
 rtl/tlc_seg_scan.sv | 115 +++++++++++
 3 files changed

// File: rtl/tlc_pkg.sv
// Shared constants for the traffic-light controller display path.
// Segment bit positions and active-low seven-segment glyphs.
package tlc_pkg;

  localparam int NDIG   = 8;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] glyph_t;

  // Bit order g..a, active-low
  localparam glyph_t GLYPH_0     = 7'b100_0000;
  localparam glyph_t GLYPH_1     = 7'b111_1001;
  localparam glyph_t GLYPH_2     = 7'b010_0100;
  localparam glyph_t GLYPH_3     = 7'b011_0000;
  localparam glyph_t GLYPH_4     = 7'b001_1001;
  localparam glyph_t GLYPH_5     = 7'b001_0010;
  localparam glyph_t GLYPH_6     = 7'b000_0010;
  localparam glyph_t GLYPH_7     = 7'b111_1000;
  localparam glyph_t GLYPH_8     = 7'b000_0000;
  localparam glyph_t GLYPH_9     = 7'b001_0000;
  localparam glyph_t GLYPH_DASH  = 7'b011_1111;
  localparam glyph_t GLYPH_BLANK = 7'b111_1111;

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low seven-segment pattern.
// Non-decimal codes render as a dash.
module seg7_decode
  import tlc_pkg::*;
(
  input  bcd_t   i_val,
  output glyph_t o_seg
);

  always_comb begin
    o_seg = GLYPH_DASH;
    case (i_val)
      4'd0:    o_seg = GLYPH_0;
      4'd1:    o_seg = GLYPH_1;
      4'd2:    o_seg = GLYPH_2;
      4'd3:    o_seg = GLYPH_3;
      4'd4:    o_seg = GLYPH_4;
      4'd5:    o_seg = GLYPH_5;
      4'd6:    o_seg = GLYPH_6;
      4'd7:    o_seg = GLYPH_7;
      4'd8:    o_seg = GLYPH_8;
      4'd9:    o_seg = GLYPH_9;
      default: o_seg = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/tlc_seg_scan.sv
// Multiplexed 8-digit seven-segment scanner with per-frame snapshot,
// leading-zero blanking and a blanked dead-time at each slot start.
module tlc_seg_scan
  import tlc_pkg::*;
#(
  parameter int              DIGIT_CYCLES = 100_000,
  parameter int              DEAD_CYCLES  = 1_000,
  parameter logic [NDIG-1:0] LZB_MASK     = 8'b1010_1010
)(
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [3:0]      d0,
  input  logic [3:0]      d1,
  input  logic [3:0]      d2,
  input  logic [3:0]      d3,
  input  logic [3:0]      d4,
  input  logic [3:0]      d5,
  input  logic [3:0]      d6,
  input  logic [3:0]      d7,
  input  logic [NDIG-1:0] blank,
  input  logic [NDIG-1:0] dp,
  output logic [7:0]      seg,
  output logic [NDIG-1:0] an
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] SLOT_MAX = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] DEAD_W   = CW'(DEAD_CYCLES);

  logic [CW-1:0]   r_slot;
  logic [2:0]      r_idx;
  bcd_t            r_snap_d [NDIG];
  logic [NDIG-1:0] r_snap_blank;
  logic [NDIG-1:0] r_snap_dp;
  logic [7:0]      r_seg;
  logic [NDIG-1:0] r_an;

  logic            w_frame;
  logic            w_dead;
  logic            w_dblank;
  bcd_t            w_digit;
  glyph_t          w_glyph;
  logic [7:0]      w_seg_nxt;
  logic [NDIG-1:0] w_an_nxt;

  seg7_decode u_dec (
    .i_val (w_digit),
    .o_seg (w_glyph)
  );

  always_comb begin
    w_digit  = r_snap_d[r_idx];
    w_frame  = enable && (r_idx == 3'd0) && (r_slot == '0);
    w_dead   = (r_slot < DEAD_W);
    w_dblank = r_snap_blank[r_idx] |
               (LZB_MASK[r_idx] & (w_digit == 4'd0));
    w_an_nxt = ~(8'd1 << r_idx);
    w_seg_nxt = 8'hFF;
    w_seg_nxt[SEG_DP] = ~r_snap_dp[r_idx];
    w_seg_nxt[SEG_G:SEG_A] = w_dblank ? GLYPH_BLANK : w_glyph;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_slot <= '0;
      r_idx  <= '0;
    end else if (!enable) begin
      r_slot <= '0;
      r_idx  <= '0;
    end else if (r_slot == SLOT_MAX) begin
      r_slot <= '0;
      r_idx  <= r_idx + 3'd1;
    end else begin
      r_slot <= r_slot + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NDIG; i++) r_snap_d[i] <= '0;
      r_snap_blank <= '0;
      r_snap_dp    <= '0;
    end else if (w_frame) begin
      r_snap_d[0]  <= d0;
      r_snap_d[1]  <= d1;
      r_snap_d[2]  <= d2;
      r_snap_d[3]  <= d3;
      r_snap_d[4]  <= d4;
      r_snap_d[5]  <= d5;
      r_snap_d[6]  <= d6;
      r_snap_d[7]  <= d7;
      r_snap_blank <= blank;
      r_snap_dp    <= dp;
    end
  end

  // Outputs trail the scan state by one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_an  <= '1;
      r_seg <= '1;
    end else if (!enable || w_dead) begin
      r_an  <= '1;
      r_seg <= '1;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule
